// File: rtl/dac_arb_pkg.sv
// Shared types and the round-robin pick function for the DAC sample arbiter.
package dac_arb_pkg;

  localparam int unsigned MAX_CH     = 8;
  localparam int unsigned MAX_CH_W   = 3;
  localparam int unsigned XFER_CNT_W = 16;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  // First set bit of req at or after ptr, wrapping modulo n; returns 0 when req is empty.
  function automatic logic [MAX_CH_W-1:0] rr_pick(
    input logic [MAX_CH-1:0]   req,
    input logic [MAX_CH_W-1:0] ptr,
    input int unsigned         n
  );
    logic [MAX_CH_W-1:0] idx;
    logic [MAX_CH_W-1:0] cand;
    logic                found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      cand = MAX_CH_W'((32'(ptr) + k) % n);
      if ((k < n) && !found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/dac_arb_rr_picker.sv
// Combinational rotate-priority encoder: picks the next requesting channel from the rr pointer.
module dac_arb_rr_picker
  import dac_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   idx_c,
  output logic              any_c
);

  assign idx_c = CH_W'(rr_pick(MAX_CH'(req), MAX_CH_W'(ptr), NUM_CH));
  assign any_c = |req;

endmodule

// File: rtl/dac_sample_arbiter.sv
// Round-robin scheduler sharing one SPI DAC driver among NUM_CH stream sources.
// Define DAC_ARB_HOLD_LAST_EN to re-offer the last sent sample whenever no source is pending.
module dac_sample_arbiter
  import dac_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic                     mclk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        s_axis_valid,
  output logic [NUM_CH-1:0]        s_axis_ready,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_data,
  input  logic [NUM_CH-1:0]        ch_enable,
  output logic                     dac_valid,
  input  logic                     dac_ready,
  output logic [DATA_W-1:0]        dac_data,
  output logic [CH_W-1:0]          grant_ch,
  output logic [XFER_CNT_W-1:0]    xfer_cnt
);

  arb_state_e            state, state_n;
  logic [DATA_W-1:0]     buf_q [NUM_CH];
  logic [DATA_W-1:0]     buf_n [NUM_CH];
  logic [NUM_CH-1:0]     s_axis_ready_n;
  logic                  dac_valid_n;
  logic [DATA_W-1:0]     dac_data_n;
  logic [CH_W-1:0]       grant_ch_n;
  logic [XFER_CNT_W-1:0] xfer_cnt_n;
  logic [CH_W-1:0]       rr_ptr, rr_ptr_n;

  logic [NUM_CH-1:0]     full;
  logic [NUM_CH-1:0]     load;
  logic [NUM_CH-1:0]     req;
  logic [CH_W-1:0]       pick_idx;
  logic                  pick_any;
  logic                  handshake;

`ifdef DAC_ARB_HOLD_LAST_EN
  logic                  sent_any, sent_any_n;
  logic                  is_repeat, is_repeat_n;
`endif

  // A buffer is full exactly when its ready is low.
  assign full      = ~s_axis_ready;
  assign load      = s_axis_valid & s_axis_ready;
  assign req       = full & ch_enable;
  assign handshake = dac_valid & dac_ready;

  dac_arb_rr_picker #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_picker (
    .req   (req),
    .ptr   (rr_ptr),
    .idx_c (pick_idx),
    .any_c (pick_any)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n        = state;
    buf_n          = buf_q;
    s_axis_ready_n = s_axis_ready & ~load;
    dac_valid_n    = dac_valid;
    dac_data_n     = dac_data;
    grant_ch_n     = grant_ch;
    xfer_cnt_n     = xfer_cnt;
    rr_ptr_n       = rr_ptr;
`ifdef DAC_ARB_HOLD_LAST_EN
    sent_any_n     = sent_any;
    is_repeat_n    = is_repeat;
`endif

    for (int i = 0; i < NUM_CH; i++) begin
      if (load[i]) begin
        buf_n[i] = s_axis_data[i*DATA_W +: DATA_W];
      end
    end

    case (state)
      ARB: begin
        if (pick_any) begin
          dac_data_n               = buf_q[pick_idx];
          s_axis_ready_n[pick_idx] = 1'b1;
          grant_ch_n               = pick_idx;
          dac_valid_n              = 1'b1;
          state_n                  = OFFER;
`ifdef DAC_ARB_HOLD_LAST_EN
          is_repeat_n              = 1'b0;
        end else if (sent_any) begin
          // dac_data/grant_ch still hold the last sent sample.
          dac_valid_n              = 1'b1;
          is_repeat_n              = 1'b1;
          state_n                  = OFFER;
`endif
        end else begin
          dac_valid_n              = 1'b0;
        end
      end

      OFFER: begin
        if (handshake) begin
          dac_valid_n = 1'b0;
          xfer_cnt_n  = xfer_cnt + XFER_CNT_W'(1);
          rr_ptr_n    = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
          state_n     = ARB;
`ifdef DAC_ARB_HOLD_LAST_EN
          sent_any_n  = 1'b1;
          if (is_repeat) begin
            rr_ptr_n  = rr_ptr;
          end
`endif
        end
      end

      default: begin
        dac_valid_n = 1'b0;
        state_n     = ARB;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARB;
      s_axis_ready <= '1;
      dac_valid    <= 1'b0;
      dac_data     <= '0;
      grant_ch     <= '0;
      xfer_cnt     <= '0;
      rr_ptr       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        buf_q[i] <= '0;
      end
`ifdef DAC_ARB_HOLD_LAST_EN
      sent_any     <= 1'b0;
      is_repeat    <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      s_axis_ready <= s_axis_ready_n;
      dac_valid    <= dac_valid_n;
      dac_data     <= dac_data_n;
      grant_ch     <= grant_ch_n;
      xfer_cnt     <= xfer_cnt_n;
      rr_ptr       <= rr_ptr_n;
      for (int i = 0; i < NUM_CH; i++) begin
        buf_q[i] <= buf_n[i];
      end
`ifdef DAC_ARB_HOLD_LAST_EN
      sent_any     <= sent_any_n;
      is_repeat    <= is_repeat_n;
`endif
    end
  end

endmodule

// File: tb/tb_dac_sample_arbiter.sv
// Scoreboard bench for dac_sample_arbiter; expected (channel, sample) pairs are queued as stimulus is set up.
module tb_dac_sample_arbiter;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CH_W   = 2;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic                     mclk;
  logic                     rst_n;
  logic [NUM_CH-1:0]        s_axis_valid;
  logic [NUM_CH-1:0]        s_axis_ready;
  logic [NUM_CH*DATA_W-1:0] s_axis_data;
  logic [NUM_CH-1:0]        ch_enable;
  logic                     dac_valid;
  logic                     dac_ready;
  logic [DATA_W-1:0]        dac_data;
  logic [CH_W-1:0]          grant_ch;
  logic [15:0]              xfer_cnt;

  exp_t              sb[$];
  int                n_checks;
  int                n_fail;
  logic [15:0]       exp_cnt;
  int                feed_cnt [NUM_CH];
  logic [DATA_W-1:0] feed_val [NUM_CH];

  dac_sample_arbiter #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W)
  ) dut (
    .mclk         (mclk),
    .rst_n        (rst_n),
    .s_axis_valid (s_axis_valid),
    .s_axis_ready (s_axis_ready),
    .s_axis_data  (s_axis_data),
    .ch_enable    (ch_enable),
    .dac_valid    (dac_valid),
    .dac_ready    (dac_ready),
    .dac_data     (dac_data),
    .grant_ch     (grant_ch),
    .xfer_cnt     (xfer_cnt)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int ch, input logic [DATA_W-1:0] d);
    exp_t e;
    e.ch   = CH_W'(ch);
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic feed(input int ch, input int cnt, input logic [DATA_W-1:0] val);
    feed_cnt[ch] = cnt;
    feed_val[ch] = val;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!dac_valid && n < budget) begin
      @(negedge mclk);
      n++;
    end
    if (!dac_valid) chk("valid_timeout", 32'(dac_valid), 32'd1);
  endtask

  // One-cycle dac_ready pulse; a handshake pops and checks the scoreboard.
  task automatic pulse();
    exp_t e;
    dac_ready = 1'b1;
    if (dac_valid) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_grant", 32'(grant_ch), 32'(e.ch));
        chk("sb_data", 32'(dac_data), 32'(e.data));
      end
      exp_cnt++;
    end
    @(negedge mclk);
    dac_ready = 1'b0;
    chk("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
  endtask

  task automatic do_reset();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    for (int i = 0; i < NUM_CH; i++) feed_cnt[i] = 0;
    dac_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge mclk);
    rst_n     = 1'b1;
    @(negedge mclk);
    exp_cnt   = '0;
    chk("rst_ready", 32'(s_axis_ready), 32'({NUM_CH{1'b1}}));
    chk("rst_valid", 32'(dac_valid), 32'd0);
    chk("rst_data", 32'(dac_data), 32'd0);
    chk("rst_grant", 32'(grant_ch), 32'd0);
    chk("rst_xfer", 32'(xfer_cnt), 32'd0);
  endtask

  // Source model: offers a sample whenever its buffer is free and it has samples left.
  initial begin
    s_axis_valid = '0;
    s_axis_data  = '0;
    forever begin
      @(negedge mclk);
      for (int i = 0; i < NUM_CH; i++) begin
        if (feed_cnt[i] > 0 && s_axis_ready[i] && rst_n) begin
          s_axis_valid[i]                   = 1'b1;
          s_axis_data[i*DATA_W +: DATA_W]   = feed_val[i];
          feed_cnt[i]                       = feed_cnt[i] - 1;
        end else begin
          s_axis_valid[i]                   = 1'b0;
        end
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_cnt   = '0;
    rst_n     = 1'b0;
    dac_ready = 1'b0;
    ch_enable = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      feed_cnt[i] = 0;
      feed_val[i] = '0;
    end

    // Single sample on ch0, ready pulse three cycles after valid.
    do_reset();
    feed(0, 1, 16'h1234);
    push(0, 16'h1234);
    wait_valid(20);
    chk("t1_rdy0_after_grant", 32'(s_axis_ready[0]), 32'd1);
    repeat (3) @(negedge mclk);
    pulse();
    chk("t1_data", 32'(dac_data), 32'h1234);
    chk("t1_grant", 32'(grant_ch), 32'd0);
    chk("t1_xfer", 32'(xfer_cnt), 32'd1);
    chk("t1_rdy0", 32'(s_axis_ready[0]), 32'd1);

    // No sources pending.
`ifdef DAC_ARB_HOLD_LAST_EN
    repeat (3) begin
      push(0, 16'h1234);
      wait_valid(10);
      pulse();
    end
    chk("t4_xfer", 32'(xfer_cnt), 32'd4);
`else
    chk("t1_valid_low", 32'(dac_valid), 32'd0);
    repeat (3) begin
      pulse();
      chk("t4_idle_valid", 32'(dac_valid), 32'd0);
    end
    chk("t4_xfer", 32'(xfer_cnt), 32'd1);
`endif

    // All channels kept full: strict rotation.
    do_reset();
    for (int c = 0; c < NUM_CH; c++) feed(c, 2, 16'(32'hA000 + c));
    for (int k = 0; k < 8; k++) push(k % NUM_CH, 16'(32'hA000 + (k % NUM_CH)));
    for (int k = 0; k < 8; k++) begin
      wait_valid(20);
      pulse();
    end
    chk("t2_xfer", 32'(xfer_cnt), 32'd8);

    // Masked channels are never granted and keep their samples.
    do_reset();
    ch_enable = 4'b1010;
    feed(0, 1, 16'hA000);
    feed(1, 2, 16'hA001);
    feed(2, 1, 16'hA002);
    feed(3, 2, 16'hA003);
    push(1, 16'hA001);
    push(3, 16'hA003);
    push(1, 16'hA001);
    push(3, 16'hA003);
    for (int k = 0; k < 4; k++) begin
      wait_valid(20);
      pulse();
    end
    repeat (4) @(negedge mclk);
    chk("t3_rdy0_held", 32'(s_axis_ready[0]), 32'd0);
    chk("t3_rdy2_held", 32'(s_axis_ready[2]), 32'd0);
`ifdef DAC_ARB_HOLD_LAST_EN
    chk("t3_repeat_valid", 32'(dac_valid), 32'd1);
    push(3, 16'hA003);
    pulse();
`else
    chk("t3_idle_valid", 32'(dac_valid), 32'd0);
`endif
    ch_enable = '1;
    push(0, 16'hA000);
    push(2, 16'hA002);
    for (int k = 0; k < 2; k++) begin
      wait_valid(20);
      pulse();
    end
    chk("t3_rdy0_freed", 32'(s_axis_ready[0]), 32'd1);
    chk("t3_rdy2_freed", 32'(s_axis_ready[2]), 32'd1);

    // Counter wrap from a preloaded value.
    do_reset();
    force dut.xfer_cnt = 16'hFFFE;
    @(negedge mclk);
    release dut.xfer_cnt;
    @(negedge mclk);
    exp_cnt = 16'hFFFE;
    chk("t5_preload", 32'(xfer_cnt), 32'hFFFE);
    feed(1, 2, 16'h5A5A);
    push(1, 16'h5A5A);
    push(1, 16'h5A5A);
    for (int k = 0; k < 2; k++) begin
      wait_valid(20);
      pulse();
    end
    chk("t5_wrap", 32'(xfer_cnt), 32'd0);

    // Asynchronous reset while a sample is being offered.
    do_reset();
    feed(2, 2, 16'h0BAD);
    push(2, 16'h0BAD);
    wait_valid(20);
    pulse();
    wait_valid(20);
    chk("t6_pre_grant", 32'(grant_ch), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(dac_valid), 32'd0);
    chk("t6_async_ready", 32'(s_axis_ready), 32'({NUM_CH{1'b1}}));
    chk("t6_async_xfer", 32'(xfer_cnt), 32'd0);
    chk("t6_async_data", 32'(dac_data), 32'd0);
    @(negedge mclk);
    rst_n   = 1'b1;
    exp_cnt = '0;
    feed(0, 1, 16'h0C00);
    feed(3, 1, 16'h0C03);
    push(0, 16'h0C00);
    push(3, 16'h0C03);
    for (int k = 0; k < 2; k++) begin
      wait_valid(20);
      pulse();
    end
    chk("sb_end", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
